// File: rtl/tcb_lib_logsize2byteena_split.sv
// Log-size to byte-enable converter for a half-duplex TCB bus. Requests that cross a
// data-word boundary are either split into two manager beats (read data merged) or rejected.
module tcb_lib_logsize2byteena_split #(
   parameter  int unsigned AW    = 32,
   parameter  int unsigned BEN   = 4,
   parameter  int unsigned DLY   = 1,
   parameter  bit          SPLIT = 1'b1,
   localparam int unsigned MAX   = $clog2(BEN),
   localparam int unsigned SW    = $clog2(MAX+1)
)(
   input  logic            clk,
   input  logic            rst_n,
   // subordinate side: log-size, LSB-aligned data
   input  logic            sub_vld,
   output logic            sub_rdy,
   input  logic            sub_wen,
   input  logic [AW-1:0]   sub_adr,
   input  logic [SW-1:0]   sub_siz,
   input  logic [8*BEN-1:0] sub_wdt,
   output logic [8*BEN-1:0] sub_rdt,
   output logic            sub_sts,
   // manager side: byte enables, lane-positioned data
   output logic            man_vld,
   input  logic            man_rdy,
   output logic            man_wen,
   output logic [AW-1:0]   man_adr,
   output logic [BEN-1:0]  man_ben,
   output logic [8*BEN-1:0] man_wdt,
   input  logic [8*BEN-1:0] man_rdt,
   input  logic            man_sts
);

   typedef enum logic {FIRST, SECOND} state_t;

   typedef struct packed {
      logic           vld;
      logic           fst;  // first beat of a split: capture only
      logic           spl;  // last beat of a split: merge with buffer
      logic           err;
      logic [MAX-1:0] off;
   } tag_t;

   state_t             state;
   tag_t               tag_q [DLY];
   tag_t               push;
   tag_t               tag_out;
   logic [8*BEN-1:0]   rdt_buf;
   logic               sts_buf;

   logic [MAX-1:0]     off;
   logic [MAX-1:0]     rel;
   logic [MAX-1:0]     idx;
   logic [MAX+1:0]     len;
   logic [MAX+1:0]     lim;
   logic               legal;
   logic               mis;
   logic               rej;
   logic               man_hs;
   logic               rej_hs;
   logic [BEN-1:0]     ful;
   logic [BEN-1:0]     lo_mask;
   logic [AW-1:0]      adr_aln;
   logic [8*BEN-1:0]   mrg;

   // request decode and lane mapping
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      rel     = '0;
      ful     = '0;
      lo_mask = '0;
      man_wdt = '0;
      off     = sub_adr[MAX-1:0];
      len     = (MAX+2)'(1) << sub_siz;
      lim     = (MAX+2)'(off) + len;
      legal   = (sub_siz <= SW'(MAX));
      mis     = legal && (lim > (MAX+2)'(BEN));
      rej     = !legal || (mis && !SPLIT);
      adr_aln = {sub_adr[AW-1:MAX], {MAX{1'b0}}};
      for (int i = 0; i < BEN; i++) begin
         rel                = MAX'(i) - off;
         ful[i]             = ((MAX+2)'(rel) < len);
         lo_mask[i]         = (MAX'(i) < off);
         man_wdt[8*i +: 8]  = sub_wdt[8*rel +: 8];
      end
   end

   // beat control; outputs are forced quiet while reset is asserted
   always_comb begin
      man_wen = sub_wen;
      man_vld = 1'b0;
      sub_rdy = 1'b0;
      man_adr = sub_adr;
      man_ben = ful;
      rej_hs  = 1'b0;
      if (rst_n) begin
         if (state == SECOND) begin
            man_vld = sub_vld;
            man_adr = adr_aln + AW'(BEN);
            man_ben = ful & lo_mask;
            sub_rdy = man_rdy;
         end else if (rej) begin
            sub_rdy = 1'b1;
            rej_hs  = sub_vld;
         end else if (mis) begin
            man_vld = sub_vld;
            man_adr = adr_aln;
            man_ben = ful & ~lo_mask;
         end else begin
            man_vld = sub_vld;
            sub_rdy = man_rdy;
         end
      end
      man_hs   = man_vld && man_rdy;
      push     = '0;
      push.vld = man_hs || rej_hs;
      push.fst = man_hs && (state == FIRST) && mis;
      push.spl = man_hs && (state == SECOND);
      push.err = rej_hs;
      push.off = off;
   end

   assign tag_out = tag_q[DLY-1];

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FIRST;
         // NOTE: the tag line is reset so that no response can surface from a discarded split.
         for (int k = 0; k < DLY; k++) tag_q[k] <= '0;
         rdt_buf <= '0;
         sts_buf <= 1'b0;
      end else begin
         if (man_hs) state <= push.fst ? SECOND : FIRST;
         tag_q[0] <= push;
         for (int k = 1; k < DLY; k++) tag_q[k] <= tag_q[k-1];
         if (tag_out.vld && tag_out.fst) begin
            rdt_buf <= man_rdt;
            sts_buf <= man_sts;
         end
      end
   end

   // response merge and rotation back to LSB alignment
   always_comb begin
      sub_rdt = '0;
      sub_sts = 1'b0;
      idx     = '0;
      mrg     = man_rdt;
      for (int i = 0; i < BEN; i++) begin
         if (tag_out.spl && (MAX'(i) >= tag_out.off)) mrg[8*i +: 8] = rdt_buf[8*i +: 8];
      end
      if (tag_out.vld && !tag_out.fst) begin
         if (tag_out.err) begin
            sub_sts = 1'b1;
         end else begin
            for (int j = 0; j < BEN; j++) begin
               idx                = MAX'(j) + tag_out.off;
               sub_rdt[8*j +: 8]  = mrg[8*idx +: 8];
            end
            sub_sts = man_sts | (tag_out.spl & sts_buf);
         end
      end
   end

endmodule

// File: tb/tb_tcb_lib_logsize2byteena_split.sv
// Bench for tcb_lib_logsize2byteena_split (BEN=4, DLY=1): directed cases then random
// requests, checked against an address-level byte model.
module tb_tcb_lib_logsize2byteena_split;

   localparam int AW  = 32;
   localparam int BEN = 4;
   localparam int DLY = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        sub_vld = 1'b0;
   logic        sub_wen = 1'b0;
   logic [31:0] sub_adr = '0;
   logic [1:0]  sub_siz = '0;
   logic [31:0] sub_wdt = '0;
   logic        sub_rdy;
   logic [31:0] sub_rdt;
   logic        sub_sts;
   logic        man_vld;
   logic        man_wen;
   logic [31:0] man_adr;
   logic [3:0]  man_ben;
   logic [31:0] man_wdt;
   logic        man_rdy = 1'b0;
   logic [31:0] man_rdt = '0;
   logic        man_sts = 1'b0;

   // second instance with splitting disabled shares all inputs except valid
   logic        ns_vld = 1'b0;
   logic        ns_rdy;
   logic [31:0] ns_rdt;
   logic        ns_sts;
   logic        ns_man_vld;
   logic        ns_man_wen;
   logic [31:0] ns_man_adr;
   logic [3:0]  ns_man_ben;
   logic [31:0] ns_man_wdt;

   int n_chk  = 0;
   int n_fail = 0;

   bit          resp_pend = 1'b0;
   logic [31:0] resp_rdt;
   logic        resp_sts;

   always #5 clk = ~clk;

   tcb_lib_logsize2byteena_split #(.AW(AW), .BEN(BEN), .DLY(DLY), .SPLIT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .sub_vld(sub_vld), .sub_rdy(sub_rdy), .sub_wen(sub_wen), .sub_adr(sub_adr),
      .sub_siz(sub_siz), .sub_wdt(sub_wdt), .sub_rdt(sub_rdt), .sub_sts(sub_sts),
      .man_vld(man_vld), .man_rdy(man_rdy), .man_wen(man_wen), .man_adr(man_adr),
      .man_ben(man_ben), .man_wdt(man_wdt), .man_rdt(man_rdt), .man_sts(man_sts)
   );

   tcb_lib_logsize2byteena_split #(.AW(AW), .BEN(BEN), .DLY(DLY), .SPLIT(1'b0)) dut_ns (
      .clk(clk), .rst_n(rst_n),
      .sub_vld(ns_vld), .sub_rdy(ns_rdy), .sub_wen(sub_wen), .sub_adr(sub_adr),
      .sub_siz(sub_siz), .sub_wdt(sub_wdt), .sub_rdt(ns_rdt), .sub_sts(ns_sts),
      .man_vld(ns_man_vld), .man_rdy(man_rdy), .man_wen(ns_man_wen), .man_adr(ns_man_adr),
      .man_ben(ns_man_ben), .man_wdt(ns_man_wdt), .man_rdt(man_rdt), .man_sts(man_sts)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // subordinate response expected in the current cycle, or silence
   task automatic check_resp();
      if (resp_pend) begin
         check("rsp_rdt", 64'(sub_rdt), 64'(resp_rdt));
         check("rsp_sts", 64'(sub_sts), 64'(resp_sts));
         resp_pend = 1'b0;
      end else begin
         check("idle_rdt", 64'(sub_rdt), 64'd0);
         check("idle_sts", 64'(sub_sts), 64'd0);
      end
   endtask

   // advance one cycle; the manager answers a handshake in the following cycle
   task automatic next_cycle(input bit hs, input logic [31:0] w, input logic s);
      @(posedge clk);
      #1;
      if (hs) begin
         man_rdt = w;
         man_sts = s;
      end else begin
         man_rdt = $urandom;
         man_sts = 1'($urandom);
      end
   endtask

   task automatic idle(input int k);
      sub_vld = 1'b0;
      ns_vld  = 1'b0;
      for (int c = 0; c < k; c++) begin
         man_rdy = 1'($urandom);
         @(negedge clk);
         check_resp();
         check("idle_man_vld", 64'(man_vld), 64'd0);
         next_cycle(1'b0, '0, 1'b0);
      end
   endtask

   // one subordinate request on the splitting instance, checked beat by beat
   task automatic req(input logic [31:0] adr, input logic [1:0] siz, input logic wen,
                      input logic [31:0] wdt, input int st0, input int st1,
                      input logic [31:0] rw0, input logic rs0,
                      input logic [31:0] rw1, input logic rs1);
      int unsigned off, n, beats, stall;
      logic [31:0] al, wa, d, exp_wdt, exp_adr;
      logic [3:0]  exp_ben;
      logic [7:0]  wb [8];
      off   = 32'(adr[1:0]);
      n     = 32'd1 << siz;
      al    = adr - off;
      beats = (siz > 2'd2) ? 0 : ((off + n > BEN) ? 2 : 1);
      sub_vld = 1'b1;
      ns_vld  = 1'b0;
      sub_adr = adr;
      sub_siz = siz;
      sub_wen = wen;
      sub_wdt = wdt;
      for (int i = 0; i < BEN; i++)
         exp_wdt[8*i +: 8] = wdt[8*((i + BEN - int'(off)) % BEN) +: 8];
      if (beats == 0) begin
         man_rdy = 1'($urandom);
         @(negedge clk);
         check_resp();
         check("rej_man_vld", 64'(man_vld), 64'd0);
         check("rej_sub_rdy", 64'(sub_rdy), 64'd1);
         next_cycle(1'b0, '0, 1'b0);
         resp_pend = 1'b1;
         resp_rdt  = '0;
         resp_sts  = 1'b1;
      end else begin
         for (int b = 0; b < int'(beats); b++) begin
            wa = al + 32'(4*b);
            for (int i = 0; i < BEN; i++) begin
               d = wa + 32'(i) - adr;
               exp_ben[i] = (d < n);
            end
            exp_adr = (beats == 1) ? adr : wa;
            stall   = (b == 0) ? st0 : st1;
            for (int s = 0; s <= int'(stall); s++) begin
               man_rdy = (s == int'(stall));
               @(negedge clk);
               check_resp();
               check("man_vld", 64'(man_vld), 64'd1);
               check("man_adr", 64'(man_adr), 64'(exp_adr));
               check("man_ben", 64'(man_ben), 64'(exp_ben));
               check("man_wdt", 64'(man_wdt), 64'(exp_wdt));
               check("man_wen", 64'(man_wen), 64'(wen));
               check("sub_rdy", 64'(sub_rdy), 64'((b == int'(beats) - 1) && (s == int'(stall))));
               next_cycle(s == int'(stall), (b == 0) ? rw0 : rw1, (b == 0) ? rs0 : rs1);
            end
         end
         // byte j of the reply is the byte at address adr+j (split), or the j+off lane of the word
         for (int i = 0; i < BEN; i++) begin
            wb[i]     = rw0[8*i +: 8];
            wb[i + 4] = rw1[8*i +: 8];
         end
         for (int j = 0; j < BEN; j++)
            resp_rdt[8*j +: 8] = (beats == 2) ? wb[int'(off) + j] : wb[(int'(off) + j) % BEN];
         resp_sts  = (beats == 2) ? (rs0 | rs1) : rs0;
         resp_pend = 1'b1;
      end
   endtask

   // rejected request on the non-splitting instance
   task automatic rej_ns(input logic [31:0] adr, input logic [1:0] siz);
      sub_vld = 1'b0;
      ns_vld  = 1'b1;
      sub_adr = adr;
      sub_siz = siz;
      sub_wen = 1'($urandom);
      sub_wdt = $urandom;
      man_rdy = 1'b1;
      @(negedge clk);
      check_resp();
      check("ns_man_vld", 64'(ns_man_vld), 64'd0);
      check("ns_sub_rdy", 64'(ns_rdy), 64'd1);
      next_cycle(1'b0, '0, 1'b0);
      ns_vld = 1'b0;
      @(negedge clk);
      check_resp();
      check("ns_rsp_sts", 64'(ns_sts), 64'd1);
      check("ns_rsp_rdt", 64'(ns_rdt), 64'd0);
      next_cycle(1'b0, '0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] radr;
      // outputs quiet while reset is held, even with a request present
      sub_vld = 1'b1;
      sub_adr = 32'h100;
      sub_siz = 2'd2;
      man_rdy = 1'b1;
      #12;
      check("rst_man_vld", 64'(man_vld), 64'd0);
      check("rst_sub_rdy", 64'(sub_rdy), 64'd0);
      check("rst_sub_rdt", 64'(sub_rdt), 64'd0);
      check("rst_sub_sts", 64'(sub_sts), 64'd0);
      sub_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // directed cases, back to back
      req(32'h100, 2'd2, 1'b1, 32'hDDCCBBAA, 0, 0, 32'h12345678, 1'b0, '0, 1'b0);
      req(32'h102, 2'd1, 1'b0, 32'h0, 0, 0, 32'h55667788, 1'b0, '0, 1'b0);
      req(32'h103, 2'd2, 1'b1, 32'h44332211, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
      req(32'h102, 2'd2, 1'b0, 32'h0, 0, 0, 32'hBBAA0000, 1'b1, 32'h0000DDCC, 1'b0);
      req(32'h102, 2'd2, 1'b0, 32'h0, 1, 3, 32'hBBAA0000, 1'b1, 32'h0000DDCC, 1'b0);
      req(32'h000, 2'd3, 1'b0, 32'h0, 0, 0, '0, 1'b0, '0, 1'b0);
      idle(1);
      rej_ns(32'h103, 2'd1);
      rej_ns(32'h2, 2'd3);
      req(32'hFFFFFFFE, 2'd2, 1'b0, 32'h0, 0, 2, 32'hA1B2C3D4, 1'b0, 32'h0F1E2D3C, 1'b1);
      idle(2);

      // reset in the middle of a split discards it
      sub_vld = 1'b1;
      sub_adr = 32'h202;
      sub_siz = 2'd2;
      sub_wen = 1'b0;
      man_rdy = 1'b1;
      @(negedge clk);
      check_resp();
      check("pre_ben", 64'(man_ben), 64'hC);
      check("pre_rdy", 64'(sub_rdy), 64'd0);
      next_cycle(1'b1, 32'hCAFEF00D, 1'b1);
      man_rdy = 1'b0;
      @(negedge clk);
      check_resp();
      check("sec_adr", 64'(man_adr), 64'h204);
      check("sec_ben", 64'(man_ben), 64'h3);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_man_vld", 64'(man_vld), 64'd0);
      check("mid_rst_sub_rdy", 64'(sub_rdy), 64'd0);
      check("mid_rst_sub_rdt", 64'(sub_rdt), 64'd0);
      check("mid_rst_sub_sts", 64'(sub_sts), 64'd0);
      sub_vld = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(3);
      req(32'h300, 2'd2, 1'b0, 32'h0, 0, 0, 32'h89ABCDEF, 1'b0, '0, 1'b0);
      idle(1);

      // random traffic, including wrap-around addresses and stalls
      for (int t = 0; t < 150; t++) begin
         radr = $urandom;
         if ($urandom_range(0, 3) == 0) radr[31:4] = '1;
         req(radr, 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom, 1'($urandom), $urandom, 1'($urandom));
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
